// File: rtl/sdr_port_arbiter_if.sv
// sdr_port_arbiter_if: port-FIFO request bus and command/data-path bus of the SDRAM burst scheduler.
interface sdr_port_arbiter_if #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 23,
    parameter int LSIZE = 9
);
    logic [3:0]         PORT_REQ;
    logic [4*ASIZE-1:0] PORT_ADDR;
    logic [4*LSIZE-1:0] PORT_LEN;
    logic               CMD_ACK;
    logic               DATA_STB;
    logic               CMD_VALID;
    logic               CMD_WR;
    logic [ASIZE-1:0]   CMD_ADDR;
    logic [LSIZE-1:0]   CMD_LEN;
    logic [3:0]         PORT_GNT;
    logic [3:0]         PORT_DONE;
    logic [DSIZE/8-1:0] DM;

    modport master (
        input  PORT_REQ, PORT_ADDR, PORT_LEN, CMD_ACK, DATA_STB,
        output CMD_VALID, CMD_WR, CMD_ADDR, CMD_LEN, PORT_GNT, PORT_DONE, DM
    );
    modport slave (
        output PORT_REQ, PORT_ADDR, PORT_LEN, CMD_ACK, DATA_STB,
        input  CMD_VALID, CMD_WR, CMD_ADDR, CMD_LEN, PORT_GNT, PORT_DONE, DM
    );
endinterface

// File: rtl/sdr_port_arbiter.sv
// sdr_port_arbiter: round-robin burst scheduler for two write and two read SDRAM ports.
module sdr_port_arbiter #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 23,
    parameter int LSIZE = 9
) (
    input logic CLK,
    input logic RESET_N,
    sdr_port_arbiter_if.master bus
);
    localparam int MW = DSIZE / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t           state;
    logic [1:0]       rr;
    logic [1:0]       win_q;
    logic [LSIZE-1:0] cnt;
    logic [3:0]       elig;
    logic [1:0]       win;
    logic             found;

    // Descending scan so the port closest to rr is written last and wins.
    always_comb begin
        elig = '0;
        win = rr;
        found = 1'b0;
        for (int n = 0; n < 4; n++)
            elig[n] = bus.PORT_REQ[n] && (bus.PORT_LEN[n*LSIZE +: LSIZE] != '0);
        for (int i = 3; i >= 0; i--)
            if (elig[rr + 2'(i)]) begin
                win = rr + 2'(i);
                found = 1'b1;
            end
    end

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            state <= IDLE;
            rr <= '0;
            win_q <= '0;
            cnt <= '0;
            bus.CMD_VALID <= 1'b0;
            bus.CMD_WR <= 1'b0;
            bus.CMD_ADDR <= '0;
            bus.CMD_LEN <= '0;
            bus.PORT_GNT <= '0;
            bus.PORT_DONE <= '0;
            bus.DM <= {MW{1'b1}};
        end else begin
            bus.PORT_DONE <= '0;
            bus.DM <= (state == XFER && bus.CMD_WR) ? '0 : {MW{1'b1}};
            case (state)
                IDLE:
                    if (found) begin
                        state <= ISSUE;
                        win_q <= win;
                        bus.PORT_GNT <= 4'b0001 << win;
                        bus.CMD_ADDR <= bus.PORT_ADDR[win*ASIZE +: ASIZE];
                        bus.CMD_LEN <= bus.PORT_LEN[win*LSIZE +: LSIZE];
                        bus.CMD_WR <= !win[1];
                        cnt <= bus.PORT_LEN[win*LSIZE +: LSIZE];
                    end
                // An ack only counts once the command is actually presented.
                ISSUE:
                    if (bus.CMD_VALID && bus.CMD_ACK) begin
                        bus.CMD_VALID <= 1'b0;
                        state <= XFER;
                    end else
                        bus.CMD_VALID <= 1'b1;
                XFER:
                    if (bus.DATA_STB) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LSIZE'(1)) begin
                            state <= DONE;
                            bus.PORT_DONE <= bus.PORT_GNT;
                            rr <= win_q + 2'd1;
                        end
                    end
                DONE: begin
                    bus.PORT_GNT <= '0;
                    state <= IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_sdr_port_arbiter.sv
// tb_sdr_port_arbiter: directed stimulus with a queue scoreboard checked by a separate output monitor.
module tb_sdr_port_arbiter;
    localparam int DSIZE = 16, ASIZE = 23, LSIZE = 9;

    typedef struct {
        int               port;
        logic             wr;
        logic [ASIZE-1:0] addr;
        logic [LSIZE-1:0] len;
        int               dmlow;
    } exp_t;

    logic clk, rst_n;
    int errors = 0, checks = 0;
    exp_t cmd_q[$], done_q[$];
    logic [ASIZE-1:0] addr_v[4];
    logic cv_p = 1'b0;
    int dml = 0;

    sdr_port_arbiter_if #(.DSIZE(DSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE)) bus();
    sdr_port_arbiter #(.DSIZE(DSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE)) dut (
        .CLK(clk), .RESET_N(rst_n), .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endfunction

    function automatic void bad(input string n, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", n, what);
    endfunction

    task automatic set_port(input int n, input logic [LSIZE-1:0] l);
        bus.PORT_ADDR[n*ASIZE +: ASIZE] = addr_v[n];
        bus.PORT_LEN[n*LSIZE +: LSIZE] = l;
    endtask

    // Acts as the command layer for one burst; stop < len abandons it after stop strobes.
    task automatic serve(input int p, input int len, input int ackd, input int gap,
                         input logic [3:0] after, input int stop);
        exp_t e;
        int t;
        e.port = p;
        e.wr = (p < 2);
        e.addr = addr_v[p];
        e.len = LSIZE'(len);
        e.dmlow = e.wr ? len + (len - 1) * gap : 0;
        cmd_q.push_back(e);
        if (stop == len) done_q.push_back(e);
        t = 0;
        while (!bus.CMD_VALID && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.CMD_VALID) begin
            bad("cmd_timeout", "got no CMD_VALID, expected one within 20 cycles");
            return;
        end
        bus.PORT_REQ = after;
        repeat (ackd) @(negedge clk);
        bus.CMD_ACK = 1'b1;
        @(negedge clk);
        bus.CMD_ACK = 1'b0;
        for (int i = 0; i < stop; i++) begin
            bus.DATA_STB = 1'b1;
            @(negedge clk);
            bus.DATA_STB = 1'b0;
            if (i < stop - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, "_dm"}, 32'(bus.DM), 32'h3);
        chk({n, "_gnt"}, 32'(bus.PORT_GNT), 0);
        chk({n, "_cv"}, 32'(bus.CMD_VALID), 0);
        chk({n, "_done"}, 32'(bus.PORT_DONE), 0);
    endtask

    // Monitor: pops the scoreboard on every new command and every DONE pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.DM == '0) dml++;
            if (bus.CMD_VALID && !cv_p) begin
                dml = 0;
                if (cmd_q.size() == 0)
                    bad("cmd_unexpected", $sformatf("got grant %b, expected no command", bus.PORT_GNT));
                else begin
                    e = cmd_q.pop_front();
                    chk("gnt", 32'(bus.PORT_GNT), 32'(1) << e.port);
                    chk("cmd_wr", 32'(bus.CMD_WR), 32'(e.wr));
                    chk("cmd_addr", 32'(bus.CMD_ADDR), 32'(e.addr));
                    chk("cmd_len", 32'(bus.CMD_LEN), 32'(e.len));
                end
            end
            if (bus.PORT_DONE != '0) begin
                if (done_q.size() == 0)
                    bad("done_unexpected", $sformatf("got PORT_DONE %b, expected none", bus.PORT_DONE));
                else begin
                    e = done_q.pop_front();
                    chk("done", 32'(bus.PORT_DONE), 32'(1) << e.port);
                    chk("dm_low_cycles", 32'(dml), 32'(e.dmlow));
                end
            end
            cv_p = bus.CMD_VALID;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int n = 0; n < 4; n++) addr_v[n] = 23'h000100 + 23'(n) * 23'h1000;
        rst_n = 1'b0;
        bus.PORT_REQ = 4'hf;
        bus.PORT_ADDR = '0;
        bus.PORT_LEN = '0;
        bus.CMD_ACK = 1'b0;
        bus.DATA_STB = 1'b0;
        for (int n = 0; n < 4; n++) set_port(n, 9'd4);
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("latency_gnt", 32'(bus.PORT_GNT), 32'h1);
        chk("latency_cv", 32'(bus.CMD_VALID), 0);
        serve(0, 4, 3, 0, 4'h0, 4);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) set_port(n, 9'd2);
        bus.PORT_REQ = 4'hf;
        serve(0, 2, 0, 0, 4'hf, 2);
        serve(1, 2, 1, 1, 4'hf, 2);
        serve(2, 2, 0, 0, 4'hf, 2);
        serve(3, 2, 2, 1, 4'hf, 2);
        serve(0, 2, 0, 0, 4'h0, 2);

        bus.PORT_REQ = 4'b0100;
        serve(2, 2, 0, 0, 4'h0, 2);
        bus.PORT_REQ = 4'b1010;
        serve(3, 2, 0, 0, 4'b0010, 2);
        serve(1, 2, 0, 0, 4'h0, 2);

        set_port(2, 9'd0);
        set_port(3, 9'd1);
        bus.PORT_REQ = 4'b1100;
        serve(3, 1, 0, 0, 4'b0100, 1);
        repeat (20) @(negedge clk);
        chk("zero_len_gnt", 32'(bus.PORT_GNT), 0);
        bus.PORT_REQ = 4'h0;

        set_port(0, 9'd8);
        bus.PORT_REQ = 4'b0001;
        serve(0, 8, 1, 0, 4'b0001, 2);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midburst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        serve(0, 8, 0, 0, 4'h0, 8);

        repeat (5) @(negedge clk);
        chk("pending", 32'(cmd_q.size() + done_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdr_port_arbiter.md
# sdr_port_arbiter

Four-port burst scheduler for the SDRAM controller. It arbitrates round-robin between two write ports (0, 1) and two read ports (2, 3) and issues one burst command at a time to the command layer. It counts transferred words and drives the byte-mask input of the SDRAM data path, keeping all bytes masked outside a write data phase. It sits between the port FIFOs and the command/data-path pair.

## Interface
Parameters:
- DSIZE, 16: SDRAM data width; mask width is DSIZE/8.
- ASIZE, 23: SDRAM word-address width.
- LSIZE, 9: burst-length field width; legal lengths are 1 to 2^LSIZE-1.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- PORT_REQ  in  4  level request per port; bits 0-1 are write ports, bits 2-3 are read ports.
- PORT_ADDR  in  4*ASIZE  start address; port n occupies bits [n*ASIZE +: ASIZE].
- PORT_LEN  in  4*LSIZE  burst length in words; port n occupies bits [n*LSIZE +: LSIZE].
- CMD_ACK  in  1  command layer has accepted the pending command.
- DATA_STB  in  1  one data word transferred on the SDRAM bus this cycle.
- CMD_VALID  out  1  a command is pending.
- CMD_WR  out  1  1 = write, 0 = read; valid while CMD_VALID is high.
- CMD_ADDR  out  ASIZE  burst start address.
- CMD_LEN  out  LSIZE  burst length.
- PORT_GNT  out  4  one-hot grant, held from ARB exit until DONE.
- PORT_DONE  out  4  one-cycle pulse on the granted bit at burst completion.
- DM  out  DSIZE/8  byte masks to the data path; 1 = masked.

## Operation
- State machine with four states: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - If any eligible PORT_REQ bit is set, latch the winner: PORT_GNT, CMD_ADDR, CMD_LEN, CMD_WR = (winner < 2).
  - Load the word counter with the port's length, then go to ISSUE.
  - Otherwise stay in IDLE.
- Eligibility: a port whose PORT_LEN is 0 is ignored. It is never granted and never pulses DONE.
- Round-robin:
  - Pointer rr (2 bits); the search order is rr, rr+1, rr+2, rr+3 mod 4, and the first requesting eligible port wins.
  - On entering DONE, rr becomes winner+1 mod 4, with wrap 3 -> 0.
- ISSUE:
  - CMD_VALID = 1.
  - On CMD_ACK: CMD_VALID = 0 the next cycle, then go to XFER.
- XFER:
  - Each DATA_STB decrements the counter.
  - When DATA_STB arrives with counter == 1, go to DONE.
  - DATA_STB in any other state is ignored.
- DM:
  - All ones except in XFER with CMD_WR = 1, where it is all zeros.
  - It is registered, so it changes one cycle after the state change. This keeps it aligned with the registered DQM stage in the data path.
- DONE:
  - One cycle; pulse PORT_DONE[winner].
  - Clear PORT_GNT, then go to IDLE.
- Simultaneous events:
  - A request that drops after the grant is ignored; the burst always completes.
  - CMD_ACK outside ISSUE is ignored.
- Reset (asynchronous, any state, including mid-burst):
  - State goes to IDLE; rr = 0; counter = 0.
  - CMD_VALID = 0, CMD_WR = 0, CMD_ADDR = 0, CMD_LEN = 0.
  - PORT_GNT = 0, PORT_DONE = 0, DM = all ones.
  - A burst interrupted by reset is abandoned and gets no DONE pulse.

## Timing
- Request to CMD_VALID is 2 cycles: the request is sampled in IDLE at edge k, and CMD_VALID is high after edge k+1.
- The minimum burst overhead is IDLE -> ISSUE -> XFER -> DONE -> IDLE. A back-to-back request gets its next grant two cycles after DONE.
- PORT_GNT is stable from the edge that leaves IDLE through the DONE cycle.
- DM goes low one cycle after XFER is entered for a write, and returns to all ones one cycle after XFER is left.
- The outputs carry no combinational path from any input.

## Test plan
- Reset: hold RESET_N low with all requests set, then release. Required: DM = 0x3 (DSIZE=16), PORT_GNT = 0, CMD_VALID = 0, and the first grant goes to port 0.
- Single write:
  - Stimulus: port 0, ADDR = 0x000100, LEN = 4; CMD_ACK after 3 cycles; 4 DATA_STB pulses.
  - Required: CMD_WR = 1, CMD_ADDR = 0x000100, DM = 0 for exactly the XFER span plus one cycle of lag, and PORT_DONE = 0001 for one cycle after the 4th strobe.
- Round-robin: hold all four requests, LEN = 2 each. Required grant order: 0, 1, 2, 3, 0. Read grants keep DM = all ones.
- Wrap and skip: rr = 3, requests only on ports 1 and 3. Required: port 3 is granted, then port 1.
- Zero length: port 2 with LEN = 0, port 3 with LEN = 1. Required: only port 3 is granted, and port 2 never gets DONE.
- Reset mid-burst: assert RESET_N after 2 of 8 strobes. Required: all outputs return to their reset values immediately, with no DONE pulse, and the next grant starts a fresh burst.
